fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch unit for the RISC-V core: owns the program counter, issues one request at a time to instruction memory, and presents each fetched instruction to decode with a valid/ready handshake. It produces the instruction word whose opcode field drives the main controller, and consumes the controller's branch/jump/halt outcome back as the redirect and halt inputs. It sits between instruction memory and the decode/controller stage.

## Interface
- `PC_W`, default 32: program counter width in bits.
- `RESET_PC`, default 0: PC value loaded on reset; bits [1:0] must be 0.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: instruction memory accepts the request.
- `imem_addr` out PC_W: byte address of the request; always equals `pc`.
- `imem_rsp_valid` in 1: instruction word valid; one pulse per accepted request.
- `imem_rsp_data` in 32: instruction word.
- `inst_valid` out 1: `inst` holds a fetched instruction.
- `inst_ready` in 1: decode consumes `inst` this cycle.
- `inst` out 32: instruction to decode; NOP (`32'h00000013`) when `inst_valid`=0.
- `pc` out PC_W: address of the current instruction.
- `pc_plus4` out PC_W: `pc`+4, modulo 2^PC_W; this is the link value for JAL/JALR.
- `redirect_valid` in 1: taken branch, JAL or JALR for the current instruction.
- `redirect_target` in PC_W: next PC when `redirect_valid` is 1.
- `halt` in 1: current instruction is HALT.

## Operation
- FSM states:
  - `S_REQ`: `imem_req_valid`=1. Go to `S_WAIT` when `imem_req_ready`=1.
  - `S_WAIT`: go to `S_HOLD` when `imem_rsp_valid`=1, latching `imem_rsp_data` into `inst`.
  - `S_HOLD`: `inst_valid`=1. Leave only when `inst_ready`=1.
  - `S_HALT`: all outputs idle. No exit except reset.
- Transition out of `S_HOLD` on the handshake (`inst_valid` and `inst_ready`):
  - `halt`=1: go to `S_HALT`; `pc` does not change.
  - otherwise, `redirect_valid`=1: `pc` ← `{redirect_target[PC_W-1:2], 2'b00}`; go to `S_REQ`.
  - otherwise: `pc` ← `pc`+4; go to `S_REQ`.
- Priority when both are high: `halt` over `redirect_valid`.
- `redirect_valid` and `halt` are sampled only on the handshake cycle and ignored at all other times.
- At most one request is outstanding. `imem_rsp_valid` is ignored in every state except `S_WAIT`.
- `imem_addr`, `pc` and `inst` are held stable while their valid signal is high and not yet accepted.
- PC increment and redirect targets wrap modulo 2^PC_W; there is no fault on wrap.
- Reset values, including reset mid-operation:
  - `pc`=`RESET_PC`, state=`S_REQ`.
  - `inst_valid`=0, `inst`=NOP.
  - Any in-flight response is dropped. Instruction memory shares the same `reset`.

## Timing
- First `imem_req_valid`=1 comes in the first cycle after `reset` deasserts.
- Best-case throughput, with `imem_req_ready`=1, a response the cycle after acceptance, and `inst_ready`=1: one instruction every 3 cycles (`S_REQ` → `S_WAIT` → `S_HOLD`).
- `inst_valid` rises the cycle after `imem_rsp_valid`.
- The new `pc` is visible the cycle after the handshake.
- `inst_valid`, `imem_req_valid` and `pc_plus4` are registered or pure functions of registered state. There are no combinational input-to-output paths except `inst` (registered) and `imem_addr` = `pc`.

## Configuration
- Macro: `FETCH_PERF_EN`.
- Defined: adds two output ports, each a 32-bit counter that saturates at `32'hFFFFFFFF` and resets to 0:
  - `perf_fetched`: increments on every accepted instruction handshake.
  - `perf_stall`: increments every cycle spent in `S_REQ` or `S_WAIT`.
- Undefined: the ports and the counters are absent. Functional behaviour is identical in both builds.

## Structure
- Shared package `riscv_pkg` holds:
  - `fetch_state_t` enum (`S_REQ`, `S_WAIT`, `S_HOLD`, `S_HALT`).
  - `INST_NOP` = `32'h00000013`.
  - opcode constants `OP_JAL`, `OP_JALR`, `OP_HALT`, shared with the controller.
- One sub-module, `fetch_perf_counters`, holds both counters. It is instantiated only under `FETCH_PERF_EN`.

## Test plan
- **Reset, sequential fetch:** reset, then memory with 1-cycle latency returning `0x00500093` and `0x00A00113`, `inst_ready`=1.
  - Expect requests at 0x0 then 0x4, `inst` showing each word in order, one instruction per 3 cycles, `pc_plus4`=0x4 then 0x8.
- **Redirect:** handshake at `pc`=0x8 with `redirect_valid`=1, `redirect_target`=0x23.
  - Next `imem_addr`=0x20.
  - `redirect_valid` pulsed in `S_WAIT` has no effect.
- **Backpressure:** `inst_ready`=0 for 5 cycles.
  - `inst`/`pc` stay stable and no new request is issued.
  - `imem_req_ready`=0 for 4 cycles holds `imem_addr` stable.
- **Halt beats redirect:** `halt`=1 and `redirect_valid`=1 on the same handshake.
  - Goes to `S_HALT`, `pc` unchanged, no further requests for 20 cycles.
  - Then assert reset: fetch restarts at `RESET_PC`.
- **Reset mid-operation and wrap:**
  - Reset asserted in `S_WAIT`: the late `imem_rsp_valid` is ignored and the first `inst` comes from a fresh request at `RESET_PC`.
  - `pc`=`2^PC_W`-4 wraps to 0.
- **`FETCH_PERF_EN` build:** after the sequential-fetch scenario with 2 instructions, `perf_fetched`=2 and `perf_stall`=4.

Source files
------------

// File: rtl/riscv_pkg.sv
// Types and constants shared by the fetch unit and the main controller.
// Opcode constants live here so both sides decode HALT/JAL/JALR identically.
package riscv_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] INST_NOP = 32'h00000013;  // addi x0, x0, 0

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_HALT = 7'b1110011;

  function automatic logic [6:0] opcode_of(input logic [31:0] word);
    return word[6:0];
  endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating fetch/stall event counters; only built when FETCH_PERF_EN is defined.
module fetch_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (fetch_inc && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
      if (stall_inc && (perf_stall != '1))   perf_stall   <= perf_stall + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// PC owner and single-outstanding instruction fetcher feeding decode.
// Optional perf counters are added when FETCH_PERF_EN is defined.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  input  logic            halt
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  fetch_state_t    state, state_next;
  logic [PC_W-1:0] pc_q, pc_next;
  logic [31:0]     inst_q;
  logic            take;

  assign take = (state == S_HOLD) && inst_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_REQ;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_REQ:   if (imem_req_ready) state_next = S_WAIT;
      S_WAIT:  if (imem_rsp_valid) state_next = S_HOLD;
      S_HOLD:  if (inst_ready)     state_next = halt ? S_HALT : S_REQ;
      default: state_next = S_HALT;
    endcase
  end

  always_comb begin
    imem_req_valid = (state == S_REQ);
    inst_valid     = (state == S_HOLD);
  end

  // Redirect targets are forced word-aligned; halt freezes the PC.
  always_comb begin
    pc_next = pc_q;
    if (take && !halt) begin
      if (redirect_valid) pc_next = redirect_target & ~PC_W'(3);
      else                pc_next = pc_q + PC_W'(4);
    end
  end

  // inst returns to NOP on hand-off so it reads NOP whenever inst_valid is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      inst_q <= INST_NOP;
    end else begin
      pc_q <= pc_next;
      if ((state == S_WAIT) && imem_rsp_valid) inst_q <= imem_rsp_data;
      else if (take)                            inst_q <= INST_NOP;
    end
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign pc_plus4  = pc_q + PC_W'(4);
  assign inst      = inst_q;

`ifdef FETCH_PERF_EN
  fetch_perf_counters u_perf (
    .clk          (clk),
    .reset        (reset),
    .fetch_inc    (take),
    .stall_inc    ((state == S_REQ) || (state == S_WAIT)),
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
  );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit; perf ports are checked when FETCH_PERF_EN is defined.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int PC_W = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus4;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_target;
  logic            halt;
`ifdef FETCH_PERF_EN
  logic [31:0]     perf_fetched;
  logic [31:0]     perf_stall;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] word;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   cyc    = 0;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt            (halt)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_stall      (perf_stall)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!imem_req_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req_seen"}, 64'(imem_req_valid), 64'd1);
  endtask

  // One request/response pair; memory answers the cycle after acceptance.
  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] word,
                       input logic redirect_in_wait);
    exp_t e;
    wait_req(tag);
    chk({tag, "_addr"}, 64'(imem_addr), 64'(addr));
    sb.push_back('{addr: addr, word: word});
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk({tag, "_no_req_in_wait"}, 64'(imem_req_valid), 64'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = word;
    if (redirect_in_wait) begin
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_0100;
    end
    tick();
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = 32'hDEAD_BEEF;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    chk({tag, "_inst_valid"}, 64'(inst_valid), 64'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_inst"}, 64'(inst), 64'(e.word));
      chk({tag, "_pc"}, 64'(pc), 64'(e.addr));
    end
  endtask

  task automatic handshake(input logic redir, input logic [31:0] tgt, input logic hlt);
    inst_ready      = 1'b1;
    redirect_valid  = redir;
    redirect_target = tgt;
    halt            = hlt;
    tick();
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    halt            = 1'b0;
  endtask

  initial begin
    int t0;
    int t1;
    int bad;

    reset           = 1'b1;
    imem_req_ready  = 1'b0;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = '0;
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    halt            = 1'b0;

    repeat (3) tick();
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'(INST_NOP));
    chk("rst_pc", 64'(pc), 64'd0);
    reset = 1'b0;
    chk("post_rst_req", 64'(imem_req_valid), 64'd1);
    chk("post_rst_pc_plus4", 64'(pc_plus4), 64'd4);

    // Sequential fetch at full rate
    fetch("f0", 32'h0, 32'h0050_0093, 1'b0);
    t0 = cyc;
    chk("f0_pc_plus4", 64'(pc_plus4), 64'd4);
    handshake(1'b0, '0, 1'b0);
    chk("seq_pc1", 64'(pc), 64'd4);
    fetch("f1", 32'h4, 32'h00A0_0113, 1'b0);
    t1 = cyc;
    chk("throughput", 64'(t1 - t0), 64'd3);
    chk("f1_pc_plus4", 64'(pc_plus4), 64'd8);
    handshake(1'b0, '0, 1'b0);
    chk("seq_pc2", 64'(pc), 64'd8);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", 64'(perf_fetched), 64'd2);
    chk("perf_stall", 64'(perf_stall), 64'd4);
`endif

    // Redirect; the one pulsed during S_WAIT must be ignored
    fetch("f2", 32'h8, 32'h00C0_0193, 1'b1);
    handshake(1'b1, 32'h23, 1'b0);
    chk("redir_addr", 64'(imem_addr), 64'h20);

    // Decode backpressure, with a stray response while holding
    fetch("f3", 32'h20, 32'h0010_0213, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hFFFF_FFFF;
      end
      tick();
      imem_rsp_valid = 1'b0;
      chk("bp_inst", 64'(inst), 64'h0010_0213);
      chk("bp_pc", 64'(pc), 64'h20);
      chk("bp_no_req", 64'(imem_req_valid), 64'd0);
    end
    handshake(1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mem_bp_addr", 64'(imem_addr), 64'h24);
      chk("mem_bp_req", 64'(imem_req_valid), 64'd1);
    end
    fetch("f4", 32'h24, 32'h0020_0293, 1'b0);

    // Wrap at top of address space
    handshake(1'b1, 32'hFFFF_FFFF, 1'b0);
    chk("wrap_pc_top", 64'(pc), 64'hFFFF_FFFC);
    fetch("f5", 32'hFFFF_FFFC, 32'h0030_0313, 1'b0);
    chk("wrap_pc_plus4", 64'(pc_plus4), 64'd0);
    handshake(1'b0, '0, 1'b0);
    chk("wrap_pc", 64'(pc), 64'd0);
    chk("wrap_addr", 64'(imem_addr), 64'd0);

    // Halt beats redirect
    fetch("f6", 32'h0, 32'h0000_0073, 1'b0);
    handshake(1'b1, 32'h40, 1'b1);
    chk("halt_pc", 64'(pc), 64'd0);
    chk("halt_inst", 64'(inst), 64'(INST_NOP));
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (imem_req_valid || inst_valid || pc != 32'h0) bad++;
    end
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    chk("halt_idle", 64'(bad), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("halt_restart_req", 64'(imem_req_valid), 64'd1);
    chk("halt_restart_addr", 64'(imem_addr), 64'd0);

    // Reset while a response is in flight
    fetch("f7", 32'h0, 32'h0040_0393, 1'b0);
    handshake(1'b1, 32'h80, 1'b0);
    wait_req("mid");
    chk("mid_addr", 64'(imem_addr), 64'h80);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset          = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_0013;
    tick();
    imem_rsp_valid = 1'b0;
    chk("mid_late_rsp_dropped", 64'(inst_valid), 64'd0);
    chk("mid_inst_nop", 64'(inst), 64'(INST_NOP));
    chk("mid_restart_addr", 64'(imem_addr), 64'd0);
    fetch("f8", 32'h0, 32'h0070_0413, 1'b0);
    handshake(1'b0, '0, 1'b0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
